// File: rtl/ica_cube_acc_if.sv
// ----------------------------------------------------------------------------
// ica_cube_acc_if
//   Bundles the sample handshake, weight inputs and result outputs of
//   ica_cube_acc. The clock and reset stay plain ports on the module.
//
//   master : the block feeding samples/weights and consuming the update
//   slave  : ica_cube_acc itself
//
//   start, in_valid, y_in, y2_in, z1_in..z4_in, w1..w4   master -> slave
//   in_ready, busy, out_valid, w1_new..w4_new, sat_flag  slave  -> master
// ----------------------------------------------------------------------------
interface ica_cube_acc_if #(
  parameter int DW = 26
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] y_in;
  logic signed [DW-1:0] y2_in;
  logic signed [DW-1:0] z1_in;
  logic signed [DW-1:0] z2_in;
  logic signed [DW-1:0] z3_in;
  logic signed [DW-1:0] z4_in;
  logic signed [DW-1:0] w1;
  logic signed [DW-1:0] w2;
  logic signed [DW-1:0] w3;
  logic signed [DW-1:0] w4;
  logic                 busy;
  logic                 out_valid;
  logic signed [DW-1:0] w1_new;
  logic signed [DW-1:0] w2_new;
  logic signed [DW-1:0] w3_new;
  logic signed [DW-1:0] w4_new;
  logic                 sat_flag;

  modport master (
    output start, in_valid, y_in, y2_in, z1_in, z2_in, z3_in, z4_in,
           w1, w2, w3, w4,
    input  in_ready, busy, out_valid, w1_new, w2_new, w3_new, w4_new, sat_flag
  );

  modport slave (
    input  start, in_valid, y_in, y2_in, z1_in, z2_in, z3_in, z4_in,
           w1, w2, w3, w4,
    output in_ready, busy, out_valid, w1_new, w2_new, w3_new, w4_new, sat_flag
  );
endinterface

// File: rtl/ica_cube_acc.sv
// ----------------------------------------------------------------------------
// ica_cube_acc
//   Cube-and-accumulate stage of a one-unit FastICA datapath. For every
//   accepted sample it forms y^3 = y^2*y and z_i*y^3 (i = 1..4), sums those
//   over 2^LOG2_N samples and then emits the kurtosis update
//   w_new_i = mean(z_i*y^3) - 3*w_i. Data are signed Q(DW-FRAC).FRAC.
//
//   Ports
//     clk_acc  in  clock, all state changes on the rising edge
//     rst_acc  in  synchronous active-high reset
//     bus      ica_cube_acc_if.slave (handshake, samples, weights, results)
//
//   Optional feature macro: ICA_CUBE_SAT_EN
//     defined   : w_new_i clamps to the DW-bit range, sat_flag reports clamps
//     undefined : w_new_i wraps to its low DW bits, sat_flag tied low
// ----------------------------------------------------------------------------
module ica_cube_acc #(
  parameter int DW     = 26,
  parameter int FRAC   = 13,
  parameter int LOG2_N = 10,
  parameter int ACC_W  = 48
) (
  input  logic          clk_acc,
  input  logic          rst_acc,
  ica_cube_acc_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

  // The result is formed wide enough that m - 3*w can never overflow.
  localparam int RW = DW + 3;

  state_t               state_q, state_d;
  logic [LOG2_N-1:0]    cnt_q;
  logic                 drain_q;
  logic                 accept;
  logic                 accept_last;
  logic                 run_start;

  logic signed [DW-1:0]    z_a     [4];
  logic signed [DW-1:0]    w_a     [4];

  logic                    v1_q;
  logic                    v2_q;
  logic signed [DW-1:0]    y3_q;
  logic signed [DW-1:0]    zd_q    [4];
  logic signed [DW-1:0]    s2_q    [4];
  logic signed [ACC_W-1:0] acc_q   [4];

  logic signed [RW-1:0]    r_w     [4];
  logic signed [DW-1:0]    r_red   [4];
  logic signed [DW-1:0]    w_new_q [4];
  logic                    out_valid_q;

  // Fixed-point multiply: full 2*DW product, keep bits [DW+FRAC-1:FRAC].
  // Bits above that are dropped, so an out-of-range product wraps.
  function automatic logic signed [DW-1:0] fx_mul(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] ax;
    logic signed [2*DW-1:0] bx;
    logic signed [2*DW-1:0] p;
    ax = {{DW{a[DW-1]}}, a};
    bx = {{DW{b[DW-1]}}, b};
    p  = ax * bx;
    return DW'(p >>> FRAC);
  endfunction

  assign z_a[0] = bus.z1_in;
  assign z_a[1] = bus.z2_in;
  assign z_a[2] = bus.z3_in;
  assign z_a[3] = bus.z4_in;
  assign w_a[0] = bus.w1;
  assign w_a[1] = bus.w2;
  assign w_a[2] = bus.w3;
  assign w_a[3] = bus.w4;

  assign run_start   = (state_q == S_IDLE) && bus.start;
  assign accept      = (state_q == S_ACC) && bus.in_valid;
  // Counter wraps to zero on the N-th accept, so all-ones marks the last one.
  assign accept_last = accept && (&cnt_q);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)  state_d = S_ACC;
      S_ACC:   if (accept_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_q)    state_d = S_OUT;
      S_OUT:                   state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_acc) begin
    if (rst_acc) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]   <= '0;
        w_new_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      // Two DRAIN cycles: drain_q is low in the first, high in the second.
      drain_q     <= (state_q == S_DRAIN) && !drain_q;
      v1_q        <= accept;
      v2_q        <= v1_q;
      out_valid_q <= (state_q == S_OUT);

      if (run_start) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end

      for (int i = 0; i < 4; i++) begin
        if (run_start) begin
          acc_q[i] <= '0;
        end else if (v2_q) begin
          acc_q[i] <= acc_q[i] + {{(ACC_W-DW){s2_q[i][DW-1]}}, s2_q[i]};
        end
        if (state_q == S_OUT) begin
          w_new_q[i] <= r_red[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath pipeline: stage 1 y^3, stage 2 z_i*y^3
  // --------------------------------------------------------------------------
  // NOTE: data registers carry no reset; they are qualified by v1_q/v2_q,
  // which are reset, so stale contents are never accumulated.
  always_ff @(posedge clk_acc) begin
    if (accept) begin
      y3_q <= fx_mul(bus.y2_in, bus.y_in);
      for (int i = 0; i < 4; i++) begin
        zd_q[i] <= z_a[i];
      end
    end
    if (v1_q) begin
      for (int i = 0; i < 4; i++) begin
        s2_q[i] <= fx_mul(zd_q[i], y3_q);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result: mean minus 3*w, then reduce to DW bits
  // --------------------------------------------------------------------------
`ifdef ICA_CUBE_SAT_EN
  localparam logic signed [RW-1:0] R_MAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN = {4'b1111, {(DW-1){1'b0}}};
  logic [3:0] clamp;
`endif

  always_comb begin
    logic signed [RW-1:0] m_v;
    logic signed [RW-1:0] wx_v;
`ifdef ICA_CUBE_SAT_EN
    clamp = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) begin
      m_v      = RW'(acc_q[i] >>> LOG2_N);
      wx_v     = {{3{w_a[i][DW-1]}}, w_a[i]};
      r_w[i]   = m_v - wx_v - (wx_v <<< 1);
      r_red[i] = DW'(r_w[i]);
`ifdef ICA_CUBE_SAT_EN
      if (r_w[i] > R_MAX) begin
        r_red[i] = {1'b0, {(DW-1){1'b1}}};
        clamp[i] = 1'b1;
      end else if (r_w[i] < R_MIN) begin
        r_red[i] = {1'b1, {(DW-1){1'b0}}};
        clamp[i] = 1'b1;
      end
`endif
    end
  end

`ifdef ICA_CUBE_SAT_EN
  logic sat_q;

  // Sticky for the run: set when OUT clamps anything, cleared by a new start.
  always_ff @(posedge clk_acc) begin
    if (rst_acc) begin
      sat_q <= 1'b0;
    end else if (run_start) begin
      sat_q <= 1'b0;
    end else if ((state_q == S_OUT) && (|clamp)) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  assign bus.sat_flag = 1'b0;
`endif

  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.w1_new    = w_new_q[0];
  assign bus.w2_new    = w_new_q[1];
  assign bus.w3_new    = w_new_q[2];
  assign bus.w4_new    = w_new_q[3];

endmodule

// File: tb/tb_ica_cube_acc.sv
// ----------------------------------------------------------------------------
// tb_ica_cube_acc
//   Directed and randomized runs of ica_cube_acc at LOG2_N = 2 (N = 4).
//   Expected updates come from an arithmetic reference model that applies
//   the fixed-point rules sample by sample on 64-bit integers.
// ----------------------------------------------------------------------------
module tb_ica_cube_acc;

  localparam int DW     = 26;
  localparam int FRAC   = 13;
  localparam int LOG2_N = 2;
  localparam int ACC_W  = 48;
  localparam int N      = 1 << LOG2_N;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  logic clk_acc = 1'b0;
  logic rst_acc;

  always #5 clk_acc = ~clk_acc;

  ica_cube_acc_if #(.DW(DW)) bus ();

  ica_cube_acc #(
    .DW     (DW),
    .FRAC   (FRAC),
    .LOG2_N (LOG2_N),
    .ACC_W  (ACC_W)
  ) dut (
    .clk_acc (clk_acc),
    .rst_acc (rst_acc),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  longint sy  [N];
  longint sy2 [N];
  longint sz  [N][4];
  longint sw  [4];
  longint exp_r [4];
  logic   exp_sat;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_acc);
    #1;
  endtask

  function automatic longint wrapn(input longint v, input int n);
    longint m;
    longint r;
    m = longint'(1) << n;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  function automatic longint rnd_dw();
    return wrapn(longint'($urandom), DW);
  endfunction

  function automatic logic signed [63:0] wnew(input int i);
    case (i)
      0:       return bus.w1_new;
      1:       return bus.w2_new;
      2:       return bus.w3_new;
      default: return bus.w4_new;
    endcase
  endfunction

  // Reference: mean over the run of trunc(z*trunc(y2*y)), minus 3*w.
  task automatic model();
    longint acc;
    longint y3;
    longint r;
    exp_sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int n = 0; n < N; n++) begin
        y3  = wrapn((sy2[n] * sy[n]) >>> FRAC, DW);
        acc = acc + wrapn((sz[n][i] * y3) >>> FRAC, DW);
      end
      r = (acc >>> LOG2_N) - 3 * sw[i];
`ifdef ICA_CUBE_SAT_EN
      if (r > MAXV) begin
        r = MAXV;
        exp_sat = 1'b1;
      end else if (r < MINV) begin
        r = MINV;
        exp_sat = 1'b1;
      end
`else
      r = wrapn(r, DW);
`endif
      exp_r[i] = r;
    end
  endtask

  task automatic drive_sample(input int n);
    bus.y_in  = sy[n][DW-1:0];
    bus.y2_in = sy2[n][DW-1:0];
    bus.z1_in = sz[n][0][DW-1:0];
    bus.z2_in = sz[n][1][DW-1:0];
    bus.z3_in = sz[n][2][DW-1:0];
    bus.z4_in = sz[n][3][DW-1:0];
  endtask

  task automatic drive_junk();
    bus.y_in  = DW'($urandom);
    bus.y2_in = DW'($urandom);
    bus.z1_in = DW'($urandom);
    bus.z2_in = DW'($urandom);
    bus.z3_in = DW'($urandom);
    bus.z4_in = DW'($urandom);
  endtask

  task automatic set_basic(input longint w0, input longint w1v,
                           input longint w2v, input longint w3v);
    for (int n = 0; n < N; n++) begin
      sy[n]    = 8192;
      sy2[n]   = 8192;
      sz[n][0] = 8192;
      sz[n][1] = 0;
      sz[n][2] = -8192;
      sz[n][3] = 4096;
    end
    sw[0] = w0;
    sw[1] = w1v;
    sw[2] = w2v;
    sw[3] = w3v;
  endtask

  // One full update run. pat[k] gives in_valid for the k-th offered cycle
  // (all ones after the pattern runs out).
  task automatic run(input string tag, input bit [0:6] pat, input bit start_in_drain);
    int n;
    int k;
    int guard;
    int lat;
    int pulses;
    bit v;
    bit acc_now;
    bus.w1 = sw[0][DW-1:0];
    bus.w2 = sw[1][DW-1:0];
    bus.w3 = sw[2][DW-1:0];
    bus.w4 = sw[3][DW-1:0];
    model();

    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check({tag, "_busy_acc"}, bus.busy, 1);

    n = 0;
    k = 0;
    guard = 0;
    while (n < N && guard < 40) begin
      v = (k < 7) ? pat[k] : 1'b1;
      k++;
      guard++;
      bus.in_valid = v;
      if (v) drive_sample(n);
      else   drive_junk();
      acc_now = v && (bus.in_ready === 1'b1);
      cycle();
      if (acc_now) n++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_accepts"}, n, N);
    check({tag, "_ready_low"}, bus.in_ready, 0);

    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      bus.start = start_in_drain && (lat == 0);
      cycle();
      lat++;
      if (lat == 1) check({tag, "_busy_drain"}, bus.busy, 1);
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, lat, 3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_w%0d_new", tag, i + 1), wnew(i), exp_r[i]);
    end
    check({tag, "_sat"}, bus.sat_flag, exp_sat);

    pulses = 0;
    repeat (6) begin
      cycle();
      if (bus.out_valid === 1'b1) pulses++;
    end
    check({tag, "_extra_pulses"}, pulses, 0);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int pulses;
    rst_acc      = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    drive_junk();
    bus.w1 = '0;
    bus.w2 = '0;
    bus.w3 = '0;
    bus.w4 = '0;
    repeat (2) cycle();

    // Reset state
    check("rst_busy",      bus.busy,      0);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sat",       bus.sat_flag,  0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_w%0d_new", i + 1), wnew(i), 0);
    rst_acc = 1'b0;
    cycle();

    // Basic run
    set_basic(0, 0, 0, 0);
    run("basic", 7'b1111111, 1'b0);
    check("basic_lit_w1", wnew(0), 8192);
    check("basic_lit_w3", wnew(2), -8192);
    check("basic_lit_w4", wnew(3), 4096);

    // Weight term
    set_basic(8192, 0, 0, -4096);
    run("weight", 7'b1111111, 1'b0);
    check("weight_lit_w1", wnew(0), -16384);
    check("weight_lit_w4", wnew(3), 16384);

    // Bubbles in in_valid
    set_basic(0, 0, 0, 0);
    run("bubble", 7'b1001101, 1'b0);

    // Overflow of the final subtraction
    set_basic(-16777216, 0, 0, 0);
    for (int n = 0; n < N; n++) for (int i = 0; i < 4; i++) sz[n][i] = 0;
    run("ovf", 7'b1111111, 1'b0);
`ifdef ICA_CUBE_SAT_EN
    check("ovf_lit_w1",  wnew(0), 33554431);
    check("ovf_lit_sat", bus.sat_flag, 1);
`else
    check("ovf_lit_w1",  wnew(0), -16777216);
    check("ovf_lit_sat", bus.sat_flag, 0);
`endif

    // Reset after two accepts abandons the run
    set_basic(0, 0, 0, 0);
    bus.start = 1'b1;
    cycle();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    drive_sample(0);
    cycle();
    drive_sample(1);
    cycle();
    bus.in_valid = 1'b0;
    rst_acc = 1'b1;
    cycle();
    rst_acc = 1'b0;
    check("midrst_busy",     bus.busy,     0);
    check("midrst_in_ready", bus.in_ready, 0);
    pulses = 0;
    repeat (8) begin
      cycle();
      if (bus.out_valid === 1'b1) pulses++;
    end
    check("midrst_no_out", pulses, 0);
    check("midrst_idle",   bus.busy, 0);
    run("after_rst", 7'b1111111, 1'b0);
    check("after_rst_lit_w1", wnew(0), 8192);

    // start pulsed during DRAIN is ignored
    set_basic(0, 0, 0, 0);
    run("drain_start", 7'b1111111, 1'b1);

    // Randomized runs, full-range data and weights, random bubbles
    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < N; n++) begin
        sy[n]  = rnd_dw();
        sy2[n] = rnd_dw();
        for (int i = 0; i < 4; i++) sz[n][i] = rnd_dw();
      end
      for (int i = 0; i < 4; i++) sw[i] = (t < 3) ? (rnd_dw() >>> 3) : rnd_dw();
      run($sformatf("rand%0d", t), 7'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
